// File: rtl/paddsb_arb.sv
// Two-port round-robin arbiter sharing one saturating nibble adder (PADDSB).
// The winner's operands are latched, added lane-wise, and returned to that port only.
module paddsb_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic        req1,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] sum,
  output logic [3:0]  sat,
  output logic        busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_opa;
  logic [15:0] r_opb;
  logic [15:0] r_sum;
  logic [15:0] w_sum;
  logic [3:0]  r_sat;
  logic [3:0]  w_sat;
  logic        r_last_gnt;
  logic        r_win;
  logic        r_gnt0;
  logic        r_gnt1;
  logic        r_done0;
  logic        r_done1;
  logic        r_busy;
  logic        w_take;
  logic        w_finish;
  logic        w_win1;

  function automatic logic f_lane_ovf(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    r = a + b;
    return (a[3] == b[3]) && (r[3] != a[3]);
  endfunction

  paddsb u_paddsb (
    .i_a   (r_opa),
    .i_b   (r_opb),
    .o_sum (w_sum)
  );

  // Saturation flags are recomputed locally rather than inferred from the adder output.
  always_comb begin
    w_sat = 4'h0;
    for (int i = 0; i < 4; i++) begin
      w_sat[i] = f_lane_ovf(r_opa[4*i +: 4], r_opb[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // On a tie the port that did not win last time takes the adder.
  always_comb begin
    w_take   = 1'b0;
    w_finish = 1'b0;
    w_win1   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_take = req0 | req1;
        if (req0 && req1) begin
          w_win1 = ~r_last_gnt;
        end else begin
          w_win1 = req1;
        end
      end
      S_BUSY: begin
        w_finish = 1'b1;
      end
      default: begin
        w_take   = 1'b0;
        w_finish = 1'b0;
        w_win1   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa      <= 16'h0000;
      r_opb      <= 16'h0000;
      r_win      <= 1'b0;
      r_last_gnt <= 1'b1;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
    end else begin
      r_gnt0 <= w_take & ~w_win1;
      r_gnt1 <= w_take & w_win1;
      if (w_take) begin
        r_opa      <= w_win1 ? a1 : a0;
        r_opb      <= w_win1 ? b1 : b0;
        r_win      <= w_win1;
        r_last_gnt <= w_win1;
      end
    end
  end

  // Result, done pulse and busy flag; sum/sat only move on a completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= 16'h0000;
      r_sat   <= 4'h0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done0 <= w_finish & ~r_win;
      r_done1 <= w_finish & r_win;
      r_busy  <= (w_state_nxt == S_BUSY);
      if (w_finish) begin
        r_sum <= w_sum;
        r_sat <= w_sat;
      end
    end
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign sum   = r_sum;
  assign sat   = r_sat;
  assign busy  = r_busy;

endmodule

// Lane-wise signed saturating add of four independent 4-bit lanes.
module paddsb (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum
);

  function automatic logic [3:0] f_sat_lane(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    logic [3:0] f;
    r = a + b;
    if ((a[3] == b[3]) && (r[3] != a[3])) begin
      f = a[3] ? 4'h8 : 4'h7;
    end else begin
      f = r;
    end
    return f;
  endfunction

  always_comb begin
    o_sum = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      o_sum[4*i +: 4] = f_sat_lane(i_a[4*i +: 4], i_b[4*i +: 4]);
    end
  end

endmodule

// File: tb/tb_paddsb_arb.sv
// Self-checking bench for paddsb_arb: directed cases plus randomized two-port stress
// checked against an integer-arithmetic saturating-add model and a transaction model.
module tb_paddsb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [15:0] sum;
  logic [3:0]  sat;

  int total = 0;
  int bad   = 0;

  paddsb_arb dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .sum(sum), .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: each lane as a signed integer, clamp to [-8,7]; returns {sat, sum}.
  function automatic logic [19:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    logic [3:0]  f;
    int x, y, t;
    for (int i = 0; i < 4; i++) begin
      x = $signed(a[4*i +: 4]);
      y = $signed(b[4*i +: 4]);
      t = x + y;
      if (t > 7) begin
        s[4*i +: 4] = 4'h7; f[i] = 1'b1;
      end else if (t < -8) begin
        s[4*i +: 4] = 4'h8; f[i] = 1'b1;
      end else begin
        s[4*i +: 4] = t[3:0]; f[i] = 1'b0;
      end
    end
    return {f, s};
  endfunction

  // One isolated request on port p starting from IDLE at a negedge.
  task automatic do_op(input bit p, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] esum, input logic [3:0] esat, input string name);
    logic [4:0] eg, ed;
    eg = p ? 5'b01001 : 5'b10001;
    ed = p ? 5'b00010 : 5'b00100;
    if (p) begin req1 = 1'b1; a1 = a; b1 = b; end
    else   begin req0 = 1'b1; a0 = a; b0 = b; end
    @(negedge clk);
    total++;
    if ({gnt0, gnt1, done0, done1, busy} !== eg) begin
      bad++; $display("FAIL %s_gnt: got %b expected %b", name, {gnt0, gnt1, done0, done1, busy}, eg);
    end
    if (p) begin req1 = 1'b0; a1 = ~a; b1 = $urandom; end
    else   begin req0 = 1'b0; a0 = ~a; b0 = $urandom; end
    @(negedge clk);
    total++;
    if ({gnt0, gnt1, done0, done1, busy} !== ed) begin
      bad++; $display("FAIL %s_done: got %b expected %b", name, {gnt0, gnt1, done0, done1, busy}, ed);
    end
    total++;
    if ({sum, sat} !== {esum, esat}) begin
      bad++; $display("FAIL %s_result: got %h/%b expected %h/%b", name, sum, sat, esum, esat);
    end
    @(negedge clk);
    total++;
    if ({gnt0, gnt1, done0, done1, busy, sum} !== {5'b00000, esum}) begin
      bad++; $display("FAIL %s_after: got %b/%h expected 00000/%h", name,
                      {gnt0, gnt1, done0, done1, busy}, sum, esum);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = 16'h0; b0 = 16'h0; a1 = 16'h0; b1 = 16'h0;
    repeat (2) @(negedge clk);
    total++;
    if ({gnt0, gnt1, done0, done1, busy, sum, sat} !== {5'b00000, 16'h0000, 4'h0}) begin
      bad++; $display("FAIL reset: got %b/%h/%b expected 00000/0000/0000",
                      {gnt0, gnt1, done0, done1, busy}, sum, sat);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({gnt0, gnt1, done0, done1, busy, sum, sat} !== {5'b00000, 16'h0000, 4'h0}) begin
        bad++; $display("FAIL idle%0d: got %b/%h/%b expected 00000/0000/0000", i,
                        {gnt0, gnt1, done0, done1, busy}, sum, sat);
      end
    end
  endtask

  task automatic test_directed();
    do_op(1'b0, 16'h1234, 16'h1111, 16'h2345, 4'b0000, "basic_p0");
    do_op(1'b1, 16'h7777, 16'h1111, 16'h7777, 4'b1111, "pos_sat_p1");
    do_op(1'b0, 16'h8888, 16'h8888, 16'h8888, 4'b1111, "neg_sat");
    do_op(1'b1, 16'h7F0F, 16'h1F01, 16'h7E00, 4'b1000, "mixed");
  endtask

  task automatic test_contention();
    logic [4:0] exp_seq [5];
    logic [15:0] exp_sum [5];
    exp_seq = '{5'b10001, 5'b00100, 5'b01001, 5'b00010, 5'b00000};
    exp_sum = '{16'h0000, 16'h0002, 16'h0002, 16'h0004, 16'h0004};
    rst = 1'b1;
    req0 = 1'b1; a0 = 16'h0001; b0 = 16'h0001;
    req1 = 1'b1; a1 = 16'h0002; b1 = 16'h0002;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({gnt0, gnt1, done0, done1, busy, sum, sat} !== {exp_seq[k], exp_sum[k], 4'h0}) begin
        bad++; $display("FAIL contend%0d: got %b/%h/%b expected %b/%h/0000", k,
                        {gnt0, gnt1, done0, done1, busy}, sum, sat, exp_seq[k], exp_sum[k]);
      end
      if (gnt0) begin req0 = 1'b0; a0 = $urandom; b0 = $urandom; end
      if (gnt1) begin req1 = 1'b0; a1 = $urandom; b1 = $urandom; end
    end
  endtask

  task automatic test_reset_busy();
    req1 = 1'b1; a1 = 16'h1234; b1 = 16'h4321;
    @(negedge clk);
    total++;
    if ({gnt0, gnt1, done0, done1, busy} !== 5'b01001) begin
      bad++; $display("FAIL rb_gnt: got %b expected 01001", {gnt0, gnt1, done0, done1, busy});
    end
    rst = 1'b1;
    #1;
    total++;
    if ({gnt0, gnt1, done0, done1, busy, sum, sat} !== {5'b00000, 16'h0000, 4'h0}) begin
      bad++; $display("FAIL rb_async: got %b/%h/%b expected 00000/0000/0000",
                      {gnt0, gnt1, done0, done1, busy}, sum, sat);
    end
    @(negedge clk);
    total++;
    if ({gnt0, gnt1, done0, done1, busy, sum} !== {5'b00000, 16'h0000}) begin
      bad++; $display("FAIL rb_held: got %b/%h expected 00000/0000", {gnt0, gnt1, done0, done1, busy}, sum);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({gnt0, gnt1, done0, done1, busy} !== 5'b01001) begin
      bad++; $display("FAIL rb_regnt: got %b expected 01001", {gnt0, gnt1, done0, done1, busy});
    end
    req1 = 1'b0; a1 = 16'hFFFF; b1 = 16'hFFFF;
    @(negedge clk);
    total++;
    if ({gnt0, gnt1, done0, done1, busy, sum, sat} !== {5'b00010, 16'h5555, 4'h0}) begin
      bad++; $display("FAIL rb_done: got %b/%h/%b expected 00010/5555/0000",
                      {gnt0, gnt1, done0, done1, busy}, sum, sat);
    end
  endtask

  // Transaction-level model: a grant is followed by exactly one done on the next cycle;
  // otherwise any pending request is granted, ties going to the port not served last.
  task automatic test_random();
    bit          rq [2];
    logic [15:0] oa [2];
    logic [15:0] ob [2];
    int          last, pend, win;
    logic [19:0] pend_res;
    logic [15:0] exp_sum;
    logic [3:0]  exp_sat;
    logic [4:0]  exp_flags;
    bit          e0, e1;
    logic [15:0] ca [2];
    logic [15:0] cb [2];
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last = 1; pend = -1; exp_sum = 16'h0; exp_sat = 4'h0; pend_res = 20'h0;
    rq[0] = 1'b0; rq[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rq[p]) begin
          oa[p] = $urandom; ob[p] = $urandom;
          if ($urandom_range(3, 0) != 0) rq[p] = 1'b1;
        end
      end
      req0 = rq[0]; a0 = oa[0]; b0 = ob[0];
      req1 = rq[1]; a1 = oa[1]; b1 = ob[1];
      e0 = rq[0]; e1 = rq[1];
      ca[0] = oa[0]; cb[0] = ob[0]; ca[1] = oa[1]; cb[1] = ob[1];
      @(negedge clk);
      win = -1;
      if (pend >= 0) begin
        exp_flags = (pend == 1) ? 5'b00010 : 5'b00100;
        exp_sat = pend_res[19:16]; exp_sum = pend_res[15:0];
        pend = -1;
      end else if (e0 || e1) begin
        if (e0 && e1) win = (last == 1) ? 0 : 1;
        else          win = e0 ? 0 : 1;
        exp_flags = (win == 1) ? 5'b01001 : 5'b10001;
        pend = win; last = win;
        pend_res = ref_add(ca[win], cb[win]);
      end else begin
        exp_flags = 5'b00000;
      end
      total++;
      if ({gnt0, gnt1, done0, done1, busy} !== exp_flags) begin
        bad++; $display("FAIL rnd_flags c=%0d: got %b expected %b", c,
                        {gnt0, gnt1, done0, done1, busy}, exp_flags);
      end
      total++;
      if ({sum, sat} !== {exp_sum, exp_sat}) begin
        bad++; $display("FAIL rnd_result c=%0d: got %h/%b expected %h/%b", c, sum, sat, exp_sum, exp_sat);
      end
      // Granted port drops its request; its operands become garbage from here on.
      if (win >= 0) begin
        rq[win] = 1'b0; oa[win] = $urandom; ob[win] = $urandom;
        if (win == 0) begin req0 = 1'b0; a0 = oa[0]; b0 = ob[0]; end
        else          begin req1 = 1'b0; a1 = oa[1]; b1 = ob[1]; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_contention();
    test_reset_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
